h264_bitpacker: RTL and testbench

- Sits directly downstream of the H.264 header/VLC stages and consumes their (VE, VL, VALID) codeword stream.
- Concatenates codewords MSB-first into a bit accumulator and emits whole bytes.
- Inserts emulation-prevention bytes (0x03) and appends RBSP trailing bits on request.
- Emits Annex-B start codes (00 00 00 01) at NAL boundaries. Its output is the byte stream handed to the bitstream writer/FIFO.

---
 rtl/h264_bitpacker.sv | 168 ++++++++++++++++
 tb/tb_h264_bitpacker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_bitpacker.sv
// h264_bitpacker: packs VLC codewords MSB-first into bytes, inserting
// emulation-prevention bytes, RBSP trailing bits and Annex-B start codes.
module h264_bitpacker #(
  parameter int ACCW = 40,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [19:0]     VE,
  input  logic [4:0]      VL,
  input  logic            VALID,
  input  logic            ALIGN,
  input  logic            NALSTART,
  output logic            READY,
  output logic [7:0]      DOUT,
  output logic            DVALID,
  input  logic            ORDY,
  output logic            ALIGNED,
  output logic [CNTW-1:0] NBYTES
);
  localparam int CW = $clog2(ACCW + 1);

  typedef enum logic [1:0] {RUN, TRAIL, DRAIN, START} state_t;

  state_t          state, n_state;
  logic [ACCW-1:0] acc, n_acc, acc1;
  logic [CW-1:0]   cnt, n_cnt, c1;
  logic [1:0]      zcnt, n_zcnt;
  logic [1:0]      sidx, n_sidx;
  logic            pend, n_pend;
  logic            dal, n_dal;
  logic            hv, n_hv;
  logic [30:0]     hw, n_hw, cw;
  logic [4:0]      hl, n_hl;
  logic            live;
  logic [7:0]      b, n_dout;
  logic            n_dv, load, emit, epb;

  // OR a codeword in right after the c valid bits; bits below cnt stay 0
  function automatic logic [ACCW-1:0] place(
    input logic [ACCW-1:0] a,
    input logic [CW-1:0]   c,
    input logic [30:0]     w,
    input logic [4:0]      l
  );
    logic [CW-1:0] sh;
    sh = CW'(ACCW) - c - CW'(l);
    return a | ({{(ACCW-31){1'b0}}, w} << sh);
  endfunction

  function automatic logic [CW-1:0] rnd8(input logic [CW-1:0] c);
    return {c[CW-1:3] + {{(CW-4){1'b0}}, |c[2:0]}, 3'b000};
  endfunction

  assign cw    = {11'b0, VE} & ((31'd1 << VL) - 31'd1);
  assign load  = !DVALID || ORDY;
  assign b     = acc[ACCW-1 -: 8];
  assign emit  = (state != START) && (cnt >= CW'(8)) && load;
  assign epb   = emit && (zcnt == 2'd2) && (b <= 8'h03);
  assign acc1  = (emit && !epb) ? acc << 8 : acc;
  assign c1    = (emit && !epb) ? cnt - CW'(8) : cnt;
  assign READY = live && (state == RUN) && (cnt <= CW'(ACCW - 31));
  assign ALIGNED = (state == DRAIN) && dal && (cnt == '0)
                && DVALID && ORDY;

  always_comb begin
    n_state = state;
    n_acc   = acc1;
    n_cnt   = c1;
    n_zcnt  = zcnt;
    n_sidx  = sidx;
    n_pend  = pend;
    n_dal   = dal;
    n_hv    = hv;
    n_hw    = hw;
    n_hl    = hl;
    n_dout  = DOUT;
    n_dv    = DVALID && !ORDY;
    if (emit) begin
      n_dv   = 1'b1;
      n_dout = epb ? 8'h03 : b;
      if (epb || b != 8'h00) n_zcnt = 2'd0;
      else n_zcnt = (zcnt == 2'd2) ? 2'd2 : zcnt + 2'd1;
    end
    unique case (state)
      RUN: if (READY) begin
        if (VALID && (ALIGN || !NALSTART)) begin
          n_acc = place(acc1, c1, cw, VL);
          n_cnt = c1 + CW'(VL);
        end
        if (ALIGN) begin
          n_state = TRAIL;
          n_dal   = 1'b1;
          n_pend  = NALSTART;
        end else if (NALSTART) begin
          // codeword sent with NALSTART belongs after the start code
          n_hv    = VALID;
          n_hw    = cw;
          n_hl    = VL;
          n_dal   = 1'b0;
          n_pend  = 1'b1;
          n_sidx  = 2'd0;
          n_cnt   = rnd8(c1);
          n_state = (rnd8(c1) != '0) ? DRAIN : START;
        end
      end
      TRAIL: if (c1 < CW'(ACCW)) begin
        n_acc   = place(acc1, c1, 31'd1, 5'd1);
        n_cnt   = rnd8(c1 + CW'(1));
        n_state = DRAIN;
      end
      DRAIN: if (cnt == '0 && load) begin
        n_state = pend ? START : RUN;
        n_pend  = 1'b0;
        n_dal   = 1'b0;
        n_sidx  = 2'd0;
      end
      START: if (load) begin
        n_dv   = 1'b1;
        n_dout = (sidx == 2'd3) ? 8'h01 : 8'h00;
        n_sidx = sidx + 2'd1;
        if (sidx == 2'd3) begin
          n_state = RUN;
          n_zcnt  = 2'd0;
          n_hv    = 1'b0;
          if (hv) begin
            n_acc = place('0, '0, hw, hl);
            n_cnt = CW'(hl);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= RUN;
      acc    <= '0;
      cnt    <= '0;
      zcnt   <= '0;
      sidx   <= '0;
      pend   <= 1'b0;
      dal    <= 1'b0;
      hv     <= 1'b0;
      hw     <= '0;
      hl     <= '0;
      live   <= 1'b0;
      DOUT   <= '0;
      DVALID <= 1'b0;
      NBYTES <= '0;
    end else begin
      state  <= n_state;
      acc    <= n_acc;
      cnt    <= n_cnt;
      zcnt   <= n_zcnt;
      sidx   <= n_sidx;
      pend   <= n_pend;
      dal    <= n_dal;
      hv     <= n_hv;
      hw     <= n_hw;
      hl     <= n_hl;
      live   <= 1'b1;
      DOUT   <= n_dout;
      DVALID <= n_dv;
      if (DVALID && ORDY) NBYTES <= NBYTES + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_h264_bitpacker.sv
// tb_h264_bitpacker: directed plus random stimulus against a
// bit-queue model of the packed H.264 byte stream.
module tb_h264_bitpacker;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [19:0] VE = '0;
  logic [4:0]  VL = '0;
  logic        VALID = 1'b0;
  logic        ALIGN = 1'b0;
  logic        NALSTART = 1'b0;
  logic        ORDY = 1'b1;
  logic        READY;
  logic [7:0]  DOUT;
  logic        DVALID;
  logic        ALIGNED;
  logic [31:0] NBYTES;

  always #5 CLK = ~CLK;

  h264_bitpacker #(.ACCW(40), .CNTW(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .VE(VE), .VL(VL), .VALID(VALID),
    .ALIGN(ALIGN), .NALSTART(NALSTART), .READY(READY), .DOUT(DOUT),
    .DVALID(DVALID), .ORDY(ORDY), .ALIGNED(ALIGNED), .NBYTES(NBYTES)
  );

  typedef logic [7:0] bq_t[$];

  int          tests = 0;
  int          fails = 0;
  bit          bitq[$];
  int          zc = 0;
  logic [7:0]  eb[$];
  bit          ea[$];
  logic [7:0]  got[$];
  int unsigned nb = 0;
  int          hold = 0;
  bit          rnd_ordy = 0;
  bit          cap_v = 0;
  logic [7:0]  cap = '0;
  bit          saw_low = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // byte former with the 00 00 0x escape rule applied in stream order
  function automatic void flush();
    while (bitq.size() >= 8) begin
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], bitq[i]};
      if (zc == 2 && v <= 8'h03) begin
        eb.push_back(8'h03); ea.push_back(1'b0); zc = 0;
      end else begin
        repeat (8) void'(bitq.pop_front());
        eb.push_back(v); ea.push_back(1'b0);
        zc = (v == 8'h00) ? ((zc < 2) ? zc + 1 : 2) : 0;
      end
    end
  endfunction

  function automatic void push_bits(logic [19:0] ve, int vl);
    logic [31:0] x = {12'b0, ve};
    for (int i = vl - 1; i >= 0; i--) bitq.push_back(x[i]);
  endfunction

  function automatic void pad();
    while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
  endfunction

  function automatic void start_code();
    eb.push_back(8'h00); eb.push_back(8'h00);
    eb.push_back(8'h00); eb.push_back(8'h01);
    repeat (4) ea.push_back(1'b0);
    zc = 0;
  endfunction

  function automatic void model(bit v, logic [19:0] ve, int vl,
                                bit al, bit ns);
    if (al) begin
      if (v) push_bits(ve, vl);
      bitq.push_back(1'b1);
      pad(); flush();
      ea[ea.size() - 1] = 1'b1;
      if (ns) start_code();
    end else if (ns) begin
      pad(); flush(); start_code();
      if (v) begin push_bits(ve, vl); flush(); end
    end else if (v) begin
      push_bits(ve, vl); flush();
    end
  endfunction

  task automatic step(input bit v, input logic [19:0] ve,
                      input logic [4:0] vl, input bit al, input bit ns,
                      output bit taken);
    @(negedge CLK);
    VALID = v; VE = ve; VL = vl; ALIGN = al; NALSTART = ns;
    if (hold > 0) ORDY = 1'b0;
    else if (rnd_ordy) ORDY = ($urandom_range(3) != 0);
    else ORDY = 1'b1;
    #1;
    if (DVALID && ORDY) begin
      if (eb.size() == 0) check("extra_byte", {31'b0, DVALID}, 32'd0);
      else begin
        check("byte", {24'b0, DOUT}, {24'b0, eb.pop_front()});
        check("aligned", {31'b0, ALIGNED}, {31'b0, ea.pop_front()});
        nb++;
        got.push_back(DOUT);
      end
    end else check("aligned_idle", {31'b0, ALIGNED}, 32'd0);
    if (hold > 0) begin
      if (!READY) saw_low = 1'b1;
      if (cap_v) begin
        check("stall_dv", {31'b0, DVALID}, 32'd1);
        check("stall_dout", {24'b0, DOUT}, {24'b0, cap});
      end else if (DVALID) begin
        cap_v = 1'b1; cap = DOUT;
      end
      hold--;
    end else cap_v = 1'b0;
    taken = READY && (v || al || ns);
    if (taken) model(v, ve, int'(vl), al, ns);
  endtask

  task automatic send(input bit v, input logic [19:0] ve,
                      input logic [4:0] vl, input bit al, input bit ns);
    bit t = 1'b0;
    int n = 0;
    do begin
      step(v, ve, vl, al, ns, t);
      n++;
    end while (!t && n < 300);
    if (!t) check("send_timeout", {31'b0, t}, 32'd1);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, t);
  endtask

  task automatic drain();
    int n = 0;
    while (eb.size() != 0 && n < 1000) begin idle(1); n++; end
    check("drain_left", eb.size(), 32'd0);
    idle(1);
    check("nbytes", NBYTES, nb);
  endtask

  task automatic expect_got(input bq_t want);
    check("seq_len", got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      if (i < got.size()) check("seq_byte", {24'b0, got[i]}, {24'b0, want[i]});
    got.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, %0d failed so far", fails);
    $fatal(1);
  end

  initial begin
    bq_t w;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_dout", {24'b0, DOUT}, 32'd0);
    check("rst_dvalid", {31'b0, DVALID}, 32'd0);
    check("rst_ready", {31'b0, READY}, 32'd0);
    check("rst_aligned", {31'b0, ALIGNED}, 32'd0);
    check("rst_nbytes", NBYTES, 32'd0);
    RSTN = 1'b1;
    #1 check("ready_at_release", {31'b0, READY}, 32'd0);
    @(negedge CLK);
    #1 check("ready_rise", {31'b0, READY}, 32'd1);

    send(1'b0, '0, '0, 1'b0, 1'b1);
    drain();
    check("ready_after_sc", {31'b0, READY}, 32'd1);
    check("nbytes_sc", NBYTES, 32'd4);
    w = '{8'h00, 8'h00, 8'h00, 8'h01};
    expect_got(w);

    send(1'b1, 20'h25, 5'd8, 1'b0, 1'b0);
    send(1'b0, '0, '0, 1'b1, 1'b0);
    drain();
    check("nbytes_t2", NBYTES, 32'd6);
    w = '{8'h25, 8'h80};
    expect_got(w);

    repeat (3) send(1'b1, 20'h0, 5'd8, 1'b0, 1'b0);
    send(1'b1, 20'h1, 5'd8, 1'b0, 1'b0);
    send(1'b0, '0, '0, 1'b1, 1'b0);
    drain();
    check("nbytes_t3", NBYTES, 32'd12);
    w = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h01, 8'h80};
    expect_got(w);

    send(1'b1, 20'h5, 5'd3, 1'b0, 1'b0);
    send(1'b1, 20'h1, 5'd31, 1'b0, 1'b0);
    send(1'b0, '0, '0, 1'b1, 1'b0);
    drain();
    check("nbytes_t4", NBYTES, 32'd18);
    w = '{8'hA0, 8'h00, 8'h00, 8'h03, 8'h00, 8'h60};
    expect_got(w);

    hold = 8; saw_low = 1'b0;
    send(1'b1, 20'($urandom), 5'd16, 1'b0, 1'b0);
    repeat (4) send(1'b1, 20'($urandom), 5'd20, 1'b0, 1'b0);
    check("ready_fell", {31'b0, saw_low}, 32'd1);
    send(1'b0, '0, '0, 1'b1, 1'b0);
    drain();
    got.delete();

    repeat (3) send(1'b1, 20'($urandom), 5'd16, 1'b0, 1'b0);
    send(1'b0, '0, '0, 1'b1, 1'b0);
    hold = 3;
    idle(3);
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("mid_rst_dvalid", {31'b0, DVALID}, 32'd0);
    check("mid_rst_nbytes", NBYTES, 32'd0);
    check("mid_rst_ready", {31'b0, READY}, 32'd0);
    bitq.delete(); eb.delete(); ea.delete(); got.delete();
    zc = 0; nb = 0; hold = 0; cap_v = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    send(1'b0, '0, '0, 1'b0, 1'b1);
    drain();
    w = '{8'h00, 8'h00, 8'h00, 8'h01};
    expect_got(w);

    rnd_ordy = 1'b1;
    for (int k = 0; k < 600; k++) begin
      int r;
      bit v, al, ns;
      r = $urandom_range(99);
      if (r < 10) idle($urandom_range(3, 1));
      else begin
        v  = (r >= 15);
        al = ($urandom_range(9) == 0);
        ns = ($urandom_range(11) == 0);
        if (!v && !al && !ns) v = 1'b1;
        send(v, 20'($urandom), 5'($urandom_range(31)), al, ns);
      end
      got.delete();
    end
    send(1'b0, '0, '0, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
